// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared defaults and pointer-width helper for the round-robin packet arbiter
package rr_arb_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 5;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin pick starting at ptr, one-hot grant plus index
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);
  logic [2*NUM_REQ-1:0] dbl;
  int pos;
  always_comb begin
    dbl = {req, req} >> ptr;
    any = 1'b0;
    idx = '0;
    pos = 0;
    // descending scan leaves the lowest rotated hit, i.e. the first at or after ptr
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        any = 1'b1;
        pos = int'(ptr) + i;
        pos = (pos >= NUM_REQ) ? pos - NUM_REQ : pos;
        idx = PTR_W'(pos);
      end
    end
    gnt = any ? (NUM_REQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter: round-robin flit arbiter with packet locking and a registered output stage
module rr_packet_arbiter
  import rr_arb_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  parameter int  DATA_W  = DEF_DATA_W,
  localparam int PTR_W   = ptr_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [PTR_W-1:0]          out_src,
  input  logic                      out_ready
);
  logic [PTR_W-1:0]   ptr_q, ptr_d, lock_idx_q, lock_idx_d, out_src_q, out_src_d;
  logic [PTR_W-1:0]   pick_idx, sel_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [DATA_W-1:0]  out_data_q, out_data_d, sel_data;
  logic               locked_q, locked_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic               pick_any, can_load, xfer, sel_last;

  rr_priority_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    can_load    = !out_valid_q || out_ready;
    sel_idx     = locked_q ? lock_idx_q : pick_idx;
    // a locked packet blocks every other channel until its last flit
    xfer        = !rst && can_load && (locked_q ? req_valid[lock_idx_q] : pick_any);
    req_ready   = xfer ? (NUM_REQ'(1) << sel_idx) : '0;
    sel_data    = req_data[sel_idx*DATA_W +: DATA_W];
    sel_last    = req_last[sel_idx];
    out_valid_d = xfer ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_data_d  = xfer ? sel_data : out_data_q;
    out_last_d  = xfer ? sel_last : out_last_q;
    out_src_d   = xfer ? sel_idx : out_src_q;
    locked_d    = xfer ? !sel_last : locked_q;
    lock_idx_d  = (xfer && !sel_last) ? sel_idx : lock_idx_q;
    ptr_d       = (xfer && sel_last) ?
                  ((sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1)) : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      locked_q    <= 1'b0;
      lock_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      locked_q    <= locked_d;
      lock_idx_q  <= lock_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
endmodule

// File: tb/tb_rr_packet_arbiter.sv
// tb_rr_packet_arbiter: scoreboard bench for the 4-channel arbiter plus a 3-channel wrap check
module tb_rr_packet_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0, req_last = '0, req_ready;
  logic [19:0] req_data = '0;
  logic        out_valid, out_last, out_ready = 1'b1;
  logic [4:0]  out_data;
  logic [1:0]  out_src;
  logic [2:0]  r3_valid = '0, r3_last = '0, r3_ready;
  logic [23:0] r3_data = '0;
  logic        o3_valid, o3_last;
  logic [7:0]  o3_data;
  logic [1:0]  o3_src;
  int          n_tests = 0, n_fail = 0;
  logic        m_ov = 1'b0;
  logic [7:0]  sb[$];
  localparam logic [19:0] D  = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [19:0] D2 = {5'd9, 5'd7, 5'd6, 5'h0A};

  rr_packet_arbiter #(.NUM_REQ(4), .DATA_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready)
  );

  rr_packet_arbiter #(.NUM_REQ(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst), .req_valid(r3_valid), .req_data(r3_data), .req_last(r3_last),
    .req_ready(r3_ready), .out_valid(o3_valid), .out_data(o3_data), .out_last(o3_last),
    .out_src(o3_src), .out_ready(1'b1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // one cycle from a negedge: drive, check expected grant, pop/push scoreboard, advance
  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic [19:0] d,
                      input logic ordy, input logic [3:0] erdy);
    int g;
    req_valid = v; req_last = l; req_data = d; out_ready = ordy;
    #1;
    chk("req_ready", 32'(req_ready), 32'(erdy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (out_valid && ordy) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
      else chk("out_flit", 32'({out_data, out_last, out_src}), 32'(sb.pop_front()));
    end
    g = -1;
    for (int i = 0; i < 4; i++) if (erdy[i]) g = i;
    if (g >= 0) begin
      sb.push_back({d[g*5 +: 5], l[g], 2'(g)});
      m_ov = 1'b1;
    end else if (ordy) m_ov = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = 4'hF; req_last = 4'hF; req_data = D;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_flit", 32'({out_valid, out_data, out_last, out_src}), 32'(0));
    rst = 1'b0;
    for (int k = 0; k < 8; k++) step(4'hF, 4'hF, D, 1'b1, 4'(1 << (k % 4)));
    step(4'h1, 4'hF, D, 1'b1, 4'h1);
    step(4'hF, 4'b1101, D, 1'b1, 4'h2);
    step(4'b1101, 4'b1101, D, 1'b1, 4'h0);
    step(4'b1101, 4'b1101, D, 1'b1, 4'h0);
    step(4'hF, 4'b1101, D, 1'b1, 4'h2);
    step(4'hF, 4'hF, D, 1'b1, 4'h2);
    step(4'b1101, 4'hF, D, 1'b1, 4'h4);
    step(4'b1001, 4'hF, D, 1'b1, 4'h8);
    step(4'b0001, 4'hF, D, 1'b1, 4'h1);
    step(4'h1, 4'hF, D2, 1'b1, 4'h1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold", 32'({out_valid, out_data, out_last, out_src}), 32'({1'b1, 5'h0A, 1'b1, 2'd0}));
      step(4'h2, 4'hF, D2, 1'b0, 4'h0);
    end
    step(4'h2, 4'hF, D2, 1'b1, 4'h2);
    step(4'b1001, 4'hF, D, 1'b1, 4'h8);
    step(4'b1001, 4'hF, D, 1'b1, 4'h1);
    step(4'h0, 4'h0, D, 1'b1, 4'h0);
    step(4'h4, 4'h0, D, 1'b1, 4'h4);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'(0));
    chk("arst_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_ov = 1'b0;
    step(4'h4, 4'hF, D, 1'b1, 4'h4);
    step(4'h2, 4'hF, D, 1'b1, 4'h2);
    step(4'h0, 4'h0, D, 1'b1, 4'h0);
    chk("sb_drained", 32'(sb.size()), 32'(0));
    req_valid = '0;
    r3_valid = 3'h7; r3_last = 3'h7; r3_data = {8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("n3_ready", 32'(r3_ready), 32'(1 << (k % 3)));
      if (k > 0) begin
        chk("n3_src", 32'(o3_src), 32'((k - 1) % 3));
        chk("n3_data", 32'(o3_data), 32'(8'h11 * (((k - 1) % 3) + 1)));
      end
      @(posedge clk);
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
